inst_mem_loadable: RTL and testbench
====================================

Name: inst_mem_loadable

Overview:
- Parametrised successor to the fixed-program instruction memory: a single-clock, synchronous-read instruction store.
- The program is loaded at runtime through a word-serial load port instead of being hard-coded.
- Sits between the program counter and the decoder, with a fetch request/valid handshake and a bounds-checked fetch.
- Raises a sticky fault on load overflow or on a fetch beyond the loaded program.

Parameters:
- DATA_W, 32: instruction word width.
- DEPTH, 128: number of instruction words; must be ≥2.
- PC_W, 32: ProgramCounter width. The PC is a word index, not a byte address.
- HALT_WORD, 32'h0400_0000: word returned on an out-of-range fetch. It is the halt opcode.

Ports:
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-low reset.
- LoadEnable  in  1  enter/restart program-load mode; clears the loaded program.
- LoadWrite  in  1  write strobe; LoadData is stored at the next sequential word.
- LoadData  in  DATA_W  instruction word being loaded.
- LoadDone  in  1  end of load; switch to run.
- FetchRequest  in  1  fetch the instruction at ProgramCounter.
- ProgramCounter  in  PC_W  word index to fetch.
- Instruction  out  DATA_W  fetched instruction, registered.
- InstructionValid  out  1  one-cycle pulse; Instruction is valid this cycle.
- Ready  out  1  high only in RUN.
- LoadCount  out  $clog2(DEPTH)+1  number of words loaded.
- Fault  out  1  sticky fault flag.
- FaultCode  out  2  0 = none, 1 = load overflow, 2 = fetch out of range.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - Instruction=0, InstructionValid=0, Ready=0, LoadCount=0, Fault=0, FaultCode=0.
  - Memory array contents are not reset.
- States: IDLE, LOAD, RUN, FAULT.
- IDLE:
  - LoadEnable → LOAD, LoadCount←0.
  - FetchRequest, LoadWrite and LoadDone are ignored; no valid pulse is produced.
- LOAD:
  - LoadWrite with LoadCount<DEPTH: mem[LoadCount]←LoadData, LoadCount+1.
  - LoadWrite with LoadCount==DEPTH: no write → FAULT, Fault=1, FaultCode=1.
  - LoadDone with LoadCount>0 after the same-cycle write → RUN.
  - LoadDone with LoadCount==0 → IDLE.
  - LoadWrite and LoadDone in the same cycle: the write is performed first and counted.
  - LoadEnable re-asserted in LOAD: LoadCount←0; a same-cycle LoadWrite is dropped.
  - FetchRequest is ignored.
- RUN (Ready=1):
  - FetchRequest at edge N: at edge N+1, InstructionValid=1.
  - In-range fetch (ProgramCounter < LoadCount, full PC_W compare, no truncation): Instruction=mem[ProgramCounter].
  - Out-of-range fetch: Instruction=HALT_WORD, InstructionValid=1, Fault=1, FaultCode=2, state → FAULT.
  - Back-to-back requests give one result per cycle; throughput is 1 fetch/cycle.
  - Without FetchRequest, InstructionValid=0 and Instruction holds its last value.
  - LoadEnable in RUN → LOAD, LoadCount←0. LoadEnable takes priority over a same-cycle FetchRequest, which produces no pulse.
  - LoadWrite and LoadDone are ignored in RUN.
- FAULT:
  - Ready=0, InstructionValid=0, Instruction holds.
  - Fault and FaultCode stay sticky.
  - The only exits are LoadEnable → LOAD (clears Fault and FaultCode, LoadCount←0) or Reset.
- Memory: one write port (LOAD only) and one registered read port (RUN only).
- Reset mid-operation: takes effect immediately. A partially loaded program is discarded (LoadCount=0). A pending fetch produces no valid pulse.

Test Plan:
- Reset with Reset=0 mid-run → all outputs 0, state IDLE; FetchRequest in IDLE → InstructionValid stays 0.
- Load 3 words 0x1BE00000, 0x38000002, 0x58060001 then LoadDone; fetch PC=0,1,2 back-to-back:
  - Ready=1, LoadCount=3.
  - Valid pulses on 3 consecutive cycles carrying those words in order, each one cycle after its request.
- Load 2 words, then fetch PC=2:
  - Next cycle Instruction=0x04000000, InstructionValid=1, Fault=1, FaultCode=2, Ready=0.
  - Further fetches give no valid pulse.
  - LoadEnable clears the fault.
- DEPTH=4, 5 LoadWrites:
  - First 4 are stored, LoadCount=4.
  - 5th gives Fault=1, FaultCode=1 and state FAULT; mem[0..3] are unchanged.
- LoadWrite of 0xAAAA0000 and LoadDone in the same cycle after 1 prior write → LoadCount=2, RUN; fetch PC=1 returns 0xAAAA0000.
- In RUN, LoadEnable and FetchRequest in the same cycle → no valid pulse, state LOAD, LoadCount=0.
- Immediate LoadDone with 0 words → state IDLE, Ready=0.

Source files
------------

// File: rtl/inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable
//
// Runtime-loadable instruction store. It sits between the program counter
// and the decoder. A program is written word by word through the load port,
// then fetched with a bounds-checked, registered read.
//
// Ports:
//   Clock            rising-edge system clock
//   Reset            asynchronous active-low reset
//   LoadEnable       enter or restart load mode; discards the loaded program
//   LoadWrite        store LoadData at the next sequential word (LOAD only)
//   LoadData         word being loaded
//   LoadDone         end of load; go to RUN, or to IDLE if nothing was loaded
//   FetchRequest     fetch the word at ProgramCounter (RUN only)
//   ProgramCounter   word index to fetch (not a byte address)
//   Instruction      fetched word, registered; holds its value between fetches
//   InstructionValid one-cycle pulse; Instruction is valid this cycle
//   Ready            high only in RUN
//   LoadCount        number of words currently loaded
//   Fault            sticky fault flag (FaultCode != 0)
//   FaultCode        0 none, 1 load overflow, 2 fetch out of range
//   DebugState       current FSM state, for checkers
//
// Handshake: Ready=1 means a FetchRequest sampled on this rising edge is
// accepted. Its result appears on the following cycle with
// InstructionValid=1. There is no back-pressure. The consumer must take the
// result on the cycle it is valid. One request per cycle is sustained.
// ---------------------------------------------------------------------------
module inst_mem_loadable #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 128,
    parameter int PC_W = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'h0400_0000
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      LoadEnable,
    input  logic                      LoadWrite,
    input  logic [DATA_W-1:0]         LoadData,
    input  logic                      LoadDone,
    input  logic                      FetchRequest,
    input  logic [PC_W-1:0]           ProgramCounter,
    output logic [DATA_W-1:0]         Instruction,
    output logic                      InstructionValid,
    output logic                      Ready,
    output logic [$clog2(DEPTH):0]    LoadCount,
    output logic                      Fault,
    output logic [1:0]                FaultCode,
    output logic [1:0]                DebugState
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W = ADDR_W + 1;
    // The range check compares in a width that fits both the PC and the
    // counter. High PC bits can never alias onto a loaded word.
    localparam int CMP_W = (PC_W > CNT_W) ? PC_W : CNT_W;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_OVERFLOW = 2'd1;
    localparam logic [1:0] FAULT_RANGE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state, stateNext;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] countAfterWrite;
    logic [1:0] faultCodeNext;
    logic memWrite;
    logic fetchHit;
    logic fetchMiss;
    logic pcInRange;
    logic [ADDR_W-1:0] pcIndex;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign pcInRange = CMP_W'(ProgramCounter) < CMP_W'(LoadCount);
    assign pcIndex = ProgramCounter[ADDR_W-1:0];

    always_comb begin
        stateNext = state;
        countNext = LoadCount;
        countAfterWrite = LoadCount;
        faultCodeNext = FaultCode;
        memWrite = 1'b0;
        fetchHit = 1'b0;
        fetchMiss = 1'b0;
        unique case (state)
            IDLE: begin
                if (LoadEnable) begin
                    stateNext = LOAD;
                    countNext = '0;
                end
            end
            LOAD: begin
                if (LoadEnable) begin
                    // A restart drops any write strobe in the same cycle.
                    countNext = '0;
                end else begin
                    if (LoadWrite) begin
                        if (LoadCount < FULL_COUNT) begin
                            memWrite = 1'b1;
                            countAfterWrite = LoadCount + CNT_W'(1);
                        end else begin
                            stateNext = FAULT;
                            faultCodeNext = FAULT_OVERFLOW;
                        end
                    end
                    countNext = countAfterWrite;
                    // LoadDone sees the count that includes a same-cycle write.
                    // An overflow fault takes precedence over LoadDone.
                    if (LoadDone && stateNext != FAULT) begin
                        stateNext = (countAfterWrite != '0) ? RUN : IDLE;
                    end
                end
            end
            RUN: begin
                if (LoadEnable) begin
                    stateNext = LOAD;
                    countNext = '0;
                end else if (FetchRequest) begin
                    if (pcInRange) begin
                        fetchHit = 1'b1;
                    end else begin
                        fetchMiss = 1'b1;
                        stateNext = FAULT;
                        faultCodeNext = FAULT_RANGE;
                    end
                end
            end
            FAULT: begin
                if (LoadEnable) begin
                    stateNext = LOAD;
                    countNext = '0;
                    faultCodeNext = FAULT_NONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            LoadCount <= '0;
            Instruction <= '0;
            InstructionValid <= 1'b0;
            FaultCode <= FAULT_NONE;
        end else begin
            state <= stateNext;
            LoadCount <= countNext;
            FaultCode <= faultCodeNext;
            InstructionValid <= fetchHit | fetchMiss;
            if (fetchHit) begin
                Instruction <= mem[pcIndex];
            end else if (fetchMiss) begin
                Instruction <= HALT_WORD;
            end
        end
    end

    // The memory array is not reset. Only words below LoadCount are ever read.
    always_ff @(posedge Clock) begin
        if (memWrite) begin
            mem[LoadCount[ADDR_W-1:0]] <= LoadData;
        end
    end

    assign Ready = (state == RUN);
    assign Fault = (FaultCode != FAULT_NONE);
    assign DebugState = state;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loadable
//
// Directed bench for inst_mem_loadable with DEPTH=4, so the load overflow
// can be reached. Fetch tasks push the expected word into exp_q. A separate
// monitor pops an entry on every InstructionValid pulse and compares it.
// Any pulse that arrives with the queue empty is an error. Status outputs
// are checked directly at chosen points.
// ---------------------------------------------------------------------------
module tb_inst_mem_loadable;

    localparam int DATA_W = 32;
    localparam int DEPTH = 4;
    localparam int PC_W = 32;
    localparam logic [DATA_W-1:0] HALT = 32'h0400_0000;
    localparam int ST_IDLE = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_RUN = 2;
    localparam int ST_FAULT = 3;

    logic Clock;
    logic Reset;
    logic LoadEnable;
    logic LoadWrite;
    logic [DATA_W-1:0] LoadData;
    logic LoadDone;
    logic FetchRequest;
    logic [PC_W-1:0] ProgramCounter;
    logic [DATA_W-1:0] Instruction;
    logic InstructionValid;
    logic Ready;
    logic [$clog2(DEPTH):0] LoadCount;
    logic Fault;
    logic [1:0] FaultCode;
    logic [1:0] DebugState;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    inst_mem_loadable #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .PC_W(PC_W),
        .HALT_WORD(HALT)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .LoadEnable(LoadEnable),
        .LoadWrite(LoadWrite),
        .LoadData(LoadData),
        .LoadDone(LoadDone),
        .FetchRequest(FetchRequest),
        .ProgramCounter(ProgramCounter),
        .Instruction(Instruction),
        .InstructionValid(InstructionValid),
        .Ready(Ready),
        .LoadCount(LoadCount),
        .Fault(Fault),
        .FaultCode(FaultCode),
        .DebugState(DebugState)
    );

    // Clock and reset.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change just after a falling edge. Outputs are read on falling
    // edges, away from the rising edge that updates them.
    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Driver tasks.
    task automatic start_load();
        LoadEnable = 1'b1;
        tick();
        LoadEnable = 1'b0;
    endtask

    task automatic load_word(input logic [DATA_W-1:0] data);
        LoadWrite = 1'b1;
        LoadData = data;
        tick();
        LoadWrite = 1'b0;
    endtask

    task automatic load_done();
        LoadDone = 1'b1;
        tick();
        LoadDone = 1'b0;
    endtask

    task automatic fetch(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] expected);
        FetchRequest = 1'b1;
        ProgramCounter = pc;
        exp_q.push_back(expected);
        tick();
        FetchRequest = 1'b0;
        check("fetch_latency_valid", 32'(InstructionValid), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge Clock) begin
        if (InstructionValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got Instruction 0x%08h expected no pulse", Instruction);
            end else begin
                check("fetch_data", Instruction, exp_q.pop_front());
            end
        end
    end

    initial begin
        Reset = 1'b0;
        LoadEnable = 1'b0;
        LoadWrite = 1'b0;
        LoadData = '0;
        LoadDone = 1'b0;
        FetchRequest = 1'b0;
        ProgramCounter = '0;
        tick();
        tick();
        Reset = 1'b1;
        tick();

        check("rst_instruction", Instruction, 32'h0);
        check("rst_valid", 32'(InstructionValid), 32'd0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_loadcount", 32'(LoadCount), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_faultcode", 32'(FaultCode), 32'd0);
        check("rst_state", 32'(DebugState), ST_IDLE);

        // A fetch in IDLE is ignored.
        FetchRequest = 1'b1;
        ProgramCounter = 0;
        tick();
        FetchRequest = 1'b0;
        tick();
        check("idle_fetch_novalid", 32'(InstructionValid), 32'd0);

        // Load three words, then fetch them back to back.
        start_load();
        check("load_state", 32'(DebugState), ST_LOAD);
        load_word(32'h1BE0_0000);
        load_word(32'h3800_0002);
        load_word(32'h5806_0001);
        load_done();
        check("run_ready", 32'(Ready), 32'd1);
        check("run_loadcount", 32'(LoadCount), 32'd3);
        fetch(0, 32'h1BE0_0000);
        fetch(1, 32'h3800_0002);
        fetch(2, 32'h5806_0001);
        tick();
        check("idle_cycle_novalid", 32'(InstructionValid), 32'd0);
        check("hold_instruction", Instruction, 32'h5806_0001);

        // Reset mid-run, with a fetch pending on the next edge.
        FetchRequest = 1'b1;
        ProgramCounter = 0;
        #2 Reset = 1'b0;
        tick();
        FetchRequest = 1'b0;
        check("midrst_instruction", Instruction, 32'h0);
        check("midrst_valid", 32'(InstructionValid), 32'd0);
        check("midrst_loadcount", 32'(LoadCount), 32'd0);
        check("midrst_state", 32'(DebugState), ST_IDLE);
        Reset = 1'b1;
        tick();

        // Out-of-range fetch.
        start_load();
        load_word(32'h1111_1111);
        load_word(32'h2222_2222);
        load_done();
        fetch(2, HALT);
        check("oor_instruction", Instruction, HALT);
        check("oor_fault", 32'(Fault), 32'd1);
        check("oor_faultcode", 32'(FaultCode), 32'd2);
        check("oor_ready", 32'(Ready), 32'd0);
        check("oor_state", 32'(DebugState), ST_FAULT);
        FetchRequest = 1'b1;
        ProgramCounter = 0;
        tick();
        tick();
        FetchRequest = 1'b0;
        check("fault_fetch_novalid", 32'(InstructionValid), 32'd0);
        check("fault_hold_instruction", Instruction, HALT);
        check("fault_sticky", 32'(FaultCode), 32'd2);
        start_load();
        check("clear_fault", 32'(Fault), 32'd0);
        check("clear_faultcode", 32'(FaultCode), 32'd0);
        check("clear_state", 32'(DebugState), ST_LOAD);
        check("clear_loadcount", 32'(LoadCount), 32'd0);

        // Load overflow with DEPTH=4.
        for (int i = 0; i < DEPTH; i++) begin
            load_word(32'hA000_0000 + 32'(i));
        end
        check("full_loadcount", 32'(LoadCount), 32'd4);
        check("full_state", 32'(DebugState), ST_LOAD);
        load_word(32'hDEAD_BEEF);
        check("ovf_fault", 32'(Fault), 32'd1);
        check("ovf_faultcode", 32'(FaultCode), 32'd1);
        check("ovf_state", 32'(DebugState), ST_FAULT);
        check("ovf_loadcount", 32'(LoadCount), 32'd4);

        // Restart in LOAD drops the same-cycle write.
        start_load();
        load_word(32'h0BAD_0001);
        LoadEnable = 1'b1;
        LoadWrite = 1'b1;
        LoadData = 32'h0BAD_0002;
        tick();
        LoadEnable = 1'b0;
        LoadWrite = 1'b0;
        check("restart_loadcount", 32'(LoadCount), 32'd0);

        // Write and LoadDone in the same cycle after one prior write.
        load_word(32'h5555_0000);
        LoadWrite = 1'b1;
        LoadData = 32'hAAAA_0000;
        LoadDone = 1'b1;
        tick();
        LoadWrite = 1'b0;
        LoadDone = 1'b0;
        check("wd_loadcount", 32'(LoadCount), 32'd2);
        check("wd_state", 32'(DebugState), ST_RUN);
        fetch(1, 32'hAAAA_0000);
        fetch(0, 32'h5555_0000);
        // The low PC bits are in range, but the full PC is not.
        fetch(32'h8000_0001, HALT);
        check("wide_pc_faultcode", 32'(FaultCode), 32'd2);

        // LoadEnable beats a same-cycle fetch in RUN.
        start_load();
        load_word(32'h7777_7777);
        load_done();
        check("run2_state", 32'(DebugState), ST_RUN);
        LoadEnable = 1'b1;
        FetchRequest = 1'b1;
        ProgramCounter = 0;
        tick();
        LoadEnable = 1'b0;
        FetchRequest = 1'b0;
        check("le_fetch_novalid", 32'(InstructionValid), 32'd0);
        check("le_fetch_state", 32'(DebugState), ST_LOAD);
        check("le_fetch_loadcount", 32'(LoadCount), 32'd0);

        // LoadDone with nothing loaded returns to IDLE.
        load_done();
        check("empty_done_state", 32'(DebugState), ST_IDLE);
        check("empty_done_ready", 32'(Ready), 32'd0);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
